// File: rtl/copy_opt_pkg.sv
// copy_opt_pkg: shared flag positions, argument bases, FSM states and flag-merge rule
package copy_opt_pkg;
  localparam int FLG_IN = 4;
  localparam int FLG_OUT = 5;
  localparam int FLG_CHAIN = 7;
  localparam logic [2:0] ARG_BASE_T0 = 3'd3;
  localparam logic [2:0] ARG_BASE_TN = 3'd4;
  typedef enum logic [2:0] {IDLE, RD_NVAL, RD_NFLG, RD_CVAL, RD_CFLG, CMP, WR_CUR, WR_NXT} state_t;
  typedef struct packed {
    logic [7:0] cur;
    logic [7:0] nxt;
    logic       inc_in;
    logic       inc_out;
  } merge_t;
  function automatic logic [2:0] arg_base(input logic [1:0] t);
    return (t == 2'd0) ? ARG_BASE_T0 : ARG_BASE_TN;
  endfunction
  // A copy-in on the next command is only kept when the current command does not
  // already bring the data in; otherwise it is chained behind the current one.
  function automatic merge_t flag_merge(input logic [7:0] c, input logic [7:0] n);
    merge_t m;
    logic p;
    p = n[FLG_IN] & ~c[FLG_IN] & ~c[FLG_CHAIN];
    m.cur = c;
    m.cur[FLG_OUT] = c[FLG_OUT] & ~n[FLG_OUT];
    m.nxt = n;
    m.nxt[FLG_IN] = p;
    m.nxt[FLG_CHAIN] = n[FLG_IN] & ~p;
    m.inc_out = c[FLG_OUT] & n[FLG_OUT];
    m.inc_in = n[FLG_IN] & (c[FLG_IN] | c[FLG_CHAIN]);
    return m;
  endfunction
endpackage

// File: rtl/copy_opt_arg_walker.sv
// copy_opt_arg_walker: n/c argument counters, word-address generation and loop termination
//   i_load        latch command descriptors and clear counters
//   i_step_c/n    advance the current-arg / next-arg counter
//   i_state       FSM state selecting which word o_addr points at
//   o_more_c/n    another c / n remains to be visited
module copy_opt_arg_walker import copy_opt_pkg::*; #(
  parameter int SB = 6,
  parameter int AB = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic [SB-1:0] i_cur_idx,
  input  logic [SB-1:0] i_next_idx,
  input  logic [1:0]    i_cur_type,
  input  logic [1:0]    i_next_type,
  input  logic [AB-1:0] i_cur_num,
  input  logic [AB-1:0] i_next_num,
  input  logic          i_assoc,
  input  logic          i_step_c,
  input  logic          i_step_n,
  input  state_t        i_state,
  output logic [SB-1:0] o_addr,
  output logic          o_more_c,
  output logic          o_more_n
);
  logic [SB-1:0] r_cbase, r_nbase, w_cflg, w_nflg;
  logic [AB-1:0] r_n, r_c, r_ccnt, r_ncnt, w_lim;
  logic          r_assoc;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cbase <= '0;
      r_nbase <= '0;
      r_ccnt <= '0;
      r_ncnt <= '0;
      r_assoc <= 1'b0;
      r_n <= '0;
      r_c <= '0;
    end else if (i_load) begin
      r_cbase <= i_cur_idx + SB'(arg_base(i_cur_type));
      r_nbase <= i_next_idx + SB'(arg_base(i_next_type));
      r_ccnt <= i_cur_num;
      r_ncnt <= i_next_num;
      r_assoc <= i_assoc;
      r_n <= '0;
      r_c <= '0;
    end else if (i_step_n) begin
      r_n <= r_n + 1'b1;
      r_c <= r_assoc ? '0 : r_n + 1'b1;
    end else if (i_step_c) begin
      r_c <= r_c + 1'b1;
    end
  end
  // Three words per argument; arithmetic stays in SB bits so the ring wraps.
  assign w_nflg = r_nbase + SB'(r_n) + SB'(r_n) + SB'(r_n);
  assign w_cflg = r_cbase + SB'(r_c) + SB'(r_c) + SB'(r_c);
  assign w_lim = r_assoc ? r_ncnt : (r_ccnt < r_ncnt ? r_ccnt : r_ncnt);
  assign o_more_n = ({1'b0, r_n} + 1'b1) < {1'b0, w_lim};
  assign o_more_c = r_assoc && (({1'b0, r_c} + 1'b1) < {1'b0, r_ccnt});
  assign o_addr = i_state == RD_NVAL ? w_nflg + 1'b1 :
                  (i_state == RD_NFLG || i_state == WR_NXT) ? w_nflg :
                  i_state == RD_CVAL ? w_cflg + 1'b1 :
                  (i_state == RD_CFLG || i_state == WR_CUR) ? w_cflg : '0;
endmodule

// File: rtl/cmd_in_copy_opt_nq.sv
// cmd_in_copy_opt_nq: copy-elimination engine rewriting copy flags of adjacent subqueue commands
//   mem_*               shared word port to NUM_QUEUES subqueue memories (1-cycle read)
//   start/queue_sel     request and target queue; cur_*/next_* describe the two commands
//   match_mode          0 positional, 1 associative argument matching
//   busy/finished       operation status and one-cycle completion pulse
//   copy_in/out_opt     saturating optimisation counters (active when DBG_REGS = 1)
module cmd_in_copy_opt_nq import copy_opt_pkg::*; #(
  parameter int SUBQUEUE_BITS = 6,
  parameter int NUM_QUEUES = 2,
  parameter int ARG_BITS = 4,
  parameter int DBG_REGS = 0
) (
  input  logic                                                clk,
  input  logic                                                rstn,
  output logic [NUM_QUEUES-1:0]                               mem_en,
  output logic [7:0]                                          mem_we,
  output logic [SUBQUEUE_BITS-1:0]                            mem_addr,
  output logic [63:0]                                         mem_din,
  input  logic [64*NUM_QUEUES-1:0]                            mem_dout,
  input  logic                                                start,
  input  logic [(NUM_QUEUES > 1 ? $clog2(NUM_QUEUES) : 1)-1:0] queue_sel,
  input  logic [SUBQUEUE_BITS-1:0]                            cur_idx,
  input  logic [SUBQUEUE_BITS-1:0]                            next_idx,
  input  logic [1:0]                                          cur_type,
  input  logic [1:0]                                          next_type,
  input  logic [ARG_BITS-1:0]                                 cur_num_args,
  input  logic [ARG_BITS-1:0]                                 next_num_args,
  input  logic                                                match_mode,
  output logic                                                busy,
  output logic                                                finished,
  output logic [31:0]                                         copy_in_opt,
  output logic [31:0]                                         copy_out_opt
);
  localparam int QW = NUM_QUEUES > 1 ? $clog2(NUM_QUEUES) : 1;
  state_t          r_state, w_next;
  logic [QW-1:0]   r_q;
  logic [63:0]     r_nval, r_cval, w_dout;
  logic [7:0]      r_nflg, r_cflg;
  logic [31:0]     r_cnt_in, r_cnt_out;
  logic            r_fin;
  logic            w_load, w_match, w_more_c, w_more_n, w_step_c, w_step_n, w_acc, w_wr;
  merge_t          w_m;
  assign w_load = r_state == IDLE && start && cur_num_args != '0 && next_num_args != '0;
  assign w_match = r_cval == r_nval;
  assign w_m = flag_merge(r_cflg, r_nflg);
  assign w_step_c = r_state == CMP && !w_match && w_more_c;
  assign w_step_n = ((r_state == CMP && !w_match && !w_more_c) || r_state == WR_NXT) && w_more_n;
  copy_opt_arg_walker #(.SB(SUBQUEUE_BITS), .AB(ARG_BITS)) u_walk (
    .clk(clk), .rstn(rstn), .i_load(w_load),
    .i_cur_idx(cur_idx), .i_next_idx(next_idx),
    .i_cur_type(cur_type), .i_next_type(next_type),
    .i_cur_num(cur_num_args), .i_next_num(next_num_args),
    .i_assoc(match_mode), .i_step_c(w_step_c), .i_step_n(w_step_n),
    .i_state(r_state), .o_addr(mem_addr), .o_more_c(w_more_c), .o_more_n(w_more_n)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_load ? RD_NVAL : IDLE;
      RD_NVAL: w_next = RD_NFLG;
      RD_NFLG: w_next = RD_CVAL;
      RD_CVAL: w_next = RD_CFLG;
      RD_CFLG: w_next = CMP;
      CMP:     w_next = w_match ? WR_CUR : w_more_c ? RD_CVAL : w_more_n ? RD_NVAL : IDLE;
      WR_CUR:  w_next = WR_NXT;
      WR_NXT:  w_next = w_more_n ? RD_NVAL : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_dout = '0;
    for (int i = 0; i < NUM_QUEUES; i++) w_dout = (r_q == QW'(i)) ? mem_dout[64*i +: 64] : w_dout;
  end
  // Read data belongs to the address issued one state earlier.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_q <= '0;
      r_fin <= 1'b0;
      r_nval <= '0;
      r_nflg <= '0;
      r_cval <= '0;
      r_cflg <= '0;
      r_cnt_in <= '0;
      r_cnt_out <= '0;
    end else begin
      r_state <= w_next;
      r_fin <= (r_state == IDLE && start && !w_load) || (r_state != IDLE && w_next == IDLE);
      if (w_load) r_q <= queue_sel;
      if (r_state == RD_NFLG) r_nval <= w_dout;
      if (r_state == RD_CVAL) r_nflg <= w_dout[7:0];
      if (r_state == RD_CFLG) r_cval <= w_dout;
      if (r_state == CMP) r_cflg <= w_dout[7:0];
      if (DBG_REGS != 0 && r_state == WR_CUR) begin
        if (w_m.inc_in && r_cnt_in != 32'hFFFF_FFFF) r_cnt_in <= r_cnt_in + 32'd1;
        if (w_m.inc_out && r_cnt_out != 32'hFFFF_FFFF) r_cnt_out <= r_cnt_out + 32'd1;
      end
    end
  end
  assign w_acc = r_state != IDLE && r_state != CMP;
  assign w_wr = r_state == WR_CUR || r_state == WR_NXT;
  assign mem_en = w_acc ? NUM_QUEUES'(1) << r_q : '0;
  assign mem_we = w_wr ? 8'h01 : 8'h00;
  assign mem_din = r_state == WR_CUR ? {56'b0, w_m.cur} : r_state == WR_NXT ? {56'b0, w_m.nxt} : '0;
  assign busy = r_state != IDLE;
  assign finished = r_fin;
  assign copy_in_opt = r_cnt_in;
  assign copy_out_opt = r_cnt_out;
endmodule

// File: tb/tb_cmd_in_copy_opt_nq.sv
// tb_cmd_in_copy_opt_nq: scoreboard bench with a 3-queue memory model and directed vectors
module tb_cmd_in_copy_opt_nq;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [2:0]   mem_en;
  logic [7:0]   mem_we;
  logic [5:0]   mem_addr;
  logic [63:0]  mem_din;
  logic [191:0] mem_dout;
  logic         start = 1'b0;
  logic [1:0]   queue_sel = '0;
  logic [5:0]   cur_idx = '0, next_idx = '0;
  logic [1:0]   cur_type = '0, next_type = '0;
  logic [3:0]   cur_num_args = '0, next_num_args = '0;
  logic         match_mode = 1'b0;
  logic         busy, finished;
  logic [31:0]  copy_in_opt, copy_out_opt;

  cmd_in_copy_opt_nq #(.SUBQUEUE_BITS(6), .NUM_QUEUES(3), .ARG_BITS(4), .DBG_REGS(1)) dut (
    .clk(clk), .rstn(rstn), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .start(start), .queue_sel(queue_sel),
    .cur_idx(cur_idx), .next_idx(next_idx), .cur_type(cur_type), .next_type(next_type),
    .cur_num_args(cur_num_args), .next_num_args(next_num_args), .match_mode(match_mode),
    .busy(busy), .finished(finished), .copy_in_opt(copy_in_opt), .copy_out_opt(copy_out_opt)
  );

  initial forever #5 clk = ~clk;

  logic [63:0] mem [3][64];
  logic [63:0] rdq [3];
  logic        tb_clr = 1'b0, tb_we = 1'b0;
  int          tb_q = 0, tb_a = 0;
  logic [63:0] tb_d = '0;
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int q = 0; q < 3; q++) for (int a = 0; a < 64; a++) mem[q][a] <= 64'h0;
    end else if (tb_we) mem[tb_q][tb_a] <= tb_d;
    for (int q = 0; q < 3; q++) if (mem_en[q]) begin
      if (mem_we[0]) mem[q][mem_addr][7:0] <= mem_din[7:0];
      rdq[q] <= mem[q][mem_addr];
    end
  end
  assign mem_dout = {rdq[2], rdq[1], rdq[0]};

  typedef struct {int id; int t0; int lat; logic [31:0] cin; logic [31:0] cout;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, fin_cnt = 0;
  int en_cnt [3] = '{0, 0, 0};
  logic [31:0] exp_cin = 0, exp_cout = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    for (int q = 0; q < 3; q++) if (mem_en[q]) en_cnt[q]++;
    if (mem_en != 3'b0) chk("mem_hi_bits", {1'b0, mem_din[63:8], mem_we[7:1]}, 64'h0);
    if (finished) begin
      fin_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_finished: got pulse want none");
      end else begin
        e = sb.pop_front();
        chk($sformatf("latency#%0d", e.id), 64'(cyc - e.t0), 64'(e.lat));
        chk($sformatf("copy_in_opt#%0d", e.id), {32'b0, copy_in_opt}, {32'b0, e.cin});
        chk($sformatf("copy_out_opt#%0d", e.id), {32'b0, copy_out_opt}, {32'b0, e.cout});
      end
    end
  end

  task automatic put(input int q, input int a, input logic [63:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_q = q; tb_a = a & 63; tb_d = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  task automatic arg(input int q, input int h, input int base, input int k,
                     input logic [63:0] f, input logic [63:0] v);
    put(q, h + base + 3 * k, f);
    put(q, h + base + 3 * k + 1, v);
  endtask

  task automatic mchk(input string nm, input int q, input int a, input logic [63:0] want);
    chk(nm, mem[q][a & 63], want);
  endtask

  task automatic run(input int id, input int q, input int ci, input int ni, input int ct,
                     input int nt, input int cn, input int nn, input int mm, input int lat);
    exp_t e;
    @(negedge clk);
    queue_sel = 2'(q); cur_idx = 6'(ci); next_idx = 6'(ni);
    cur_type = 2'(ct); next_type = 2'(nt);
    cur_num_args = 4'(cn); next_num_args = 4'(nn); match_mode = mm[0];
    start = 1'b1;
    e.id = id; e.t0 = cyc; e.lat = lat; e.cin = exp_cin; e.cout = exp_cout;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk($sformatf("completed#%0d", id), 64'(sb.size()), 64'h0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int e0 [3];
    int t, f0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_finished", {63'b0, finished}, 64'h0);
    chk("rst_mem_en_we", {53'b0, mem_en, mem_we}, 64'h0);
    chk("rst_mem_addr", {58'b0, mem_addr}, 64'h0);
    chk("rst_mem_din", mem_din, 64'h0);
    chk("rst_counters", {copy_in_opt, copy_out_opt}, 64'h0);
    rstn = 1'b1;

    // 1: positional match on arg0, C=N=0x30, upper bytes preserved
    clr();
    arg(0, 0, 3, 0, 64'hAB00_0000_0000_0030, 64'h1234);
    arg(0, 0, 3, 1, 64'h30, 64'h5555);
    arg(0, 20, 4, 0, 64'hCD00_0000_0000_0030, 64'h1234);
    arg(0, 20, 4, 1, 64'h30, 64'h6666);
    exp_cin = 1; exp_cout = 1;
    run(1, 0, 0, 20, 0, 1, 2, 2, 0, 13);
    mchk("t1_cur0", 0, 3, 64'hAB00_0000_0000_0010);
    mchk("t1_nxt0", 0, 24, 64'hCD00_0000_0000_00A0);
    mchk("t1_cur1", 0, 6, 64'h30);
    mchk("t1_nxt1", 0, 27, 64'h30);

    // 2: positional, all addresses differ
    clr();
    arg(0, 0, 3, 0, 64'h30, 64'h1234);
    arg(0, 0, 3, 1, 64'h30, 64'h5555);
    arg(0, 20, 4, 0, 64'h30, 64'h9999);
    arg(0, 20, 4, 1, 64'h30, 64'h7777);
    run(2, 0, 0, 20, 0, 1, 2, 2, 0, 11);
    mchk("t2_cur0", 0, 3, 64'h30);
    mchk("t2_nxt0", 0, 24, 64'h30);
    // 3: positional stops at min(counts)
    run(3, 0, 0, 20, 0, 1, 1, 3, 0, 6);

    // 4: associative, cur {A,B,C}, next {C,A}
    clr();
    arg(0, 0, 3, 0, 64'h10, 64'h111);
    arg(0, 0, 3, 1, 64'h10, 64'h222);
    arg(0, 0, 3, 2, 64'h10, 64'h333);
    arg(0, 30, 4, 0, 64'h10, 64'h333);
    arg(0, 30, 4, 1, 64'h10, 64'h111);
    exp_cin = 3;
    run(4, 0, 0, 30, 0, 2, 3, 2, 1, 21);
    mchk("t4_nxt0", 0, 34, 64'h80);
    mchk("t4_nxt1", 0, 37, 64'h80);
    mchk("t4_cur0", 0, 3, 64'h10);
    mchk("t4_cur2", 0, 9, 64'h10);

    // 5: cur_idx 62 wraps its argument to words 1/2
    clr();
    arg(0, 62, 3, 0, 64'h20, 64'h42);
    arg(0, 10, 4, 0, 64'h20, 64'h42);
    exp_cout = 2;
    run(5, 0, 62, 10, 0, 1, 1, 1, 0, 8);
    mchk("t5_cur_wrap", 0, 1, 64'h00);
    mchk("t5_cur_val", 0, 2, 64'h42);
    mchk("t5_nxt", 0, 14, 64'h20);

    // 6: queue 1 only, chained copy-in
    clr();
    arg(1, 5, 4, 0, 64'h80, 64'h77);
    arg(1, 40, 3, 0, 64'h10, 64'h77);
    exp_cin = 4;
    e0 = en_cnt;
    run(6, 1, 5, 40, 1, 0, 1, 1, 0, 8);
    chk("t6_en_q0", 64'(en_cnt[0] - e0[0]), 64'h0);
    chk("t6_en_q1", 64'(en_cnt[1] - e0[1]), 64'd6);
    chk("t6_en_q2", 64'(en_cnt[2] - e0[2]), 64'h0);
    mchk("t6_nxt", 1, 43, 64'h80);
    mchk("t6_cur", 1, 9, 64'h80);

    // 7: zero next args
    e0 = en_cnt;
    run(7, 0, 0, 20, 0, 1, 2, 0, 0, 1);
    chk("t7_no_access", 64'(en_cnt[0] + en_cnt[1] + en_cnt[2] - e0[0] - e0[1] - e0[2]), 64'h0);

    // 8: saturated counter holds
    clr();
    arg(0, 0, 3, 0, 64'h30, 64'h5);
    arg(0, 20, 4, 0, 64'h30, 64'h5);
    @(negedge clk);
    force dut.r_cnt_out = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_cnt_out;
    exp_cin = 5; exp_cout = 32'hFFFF_FFFF;
    run(8, 0, 0, 20, 0, 1, 1, 1, 0, 8);

    // 9: reset during CMP aborts without finished
    clr();
    arg(0, 0, 3, 0, 64'h30, 64'h5);
    arg(0, 20, 4, 0, 64'h30, 64'h5);
    @(negedge clk);
    queue_sel = 2'd0; cur_idx = 6'd0; next_idx = 6'd20; cur_type = 2'd0; next_type = 2'd1;
    cur_num_args = 4'd1; next_num_args = 4'd1; match_mode = 1'b0; start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t9_busy_before", {63'b0, busy}, 64'h1);
    f0 = fin_cnt;
    rstn = 1'b0;
    #1;
    chk("t9_busy", {63'b0, busy}, 64'h0);
    chk("t9_mem_en", {61'b0, mem_en}, 64'h0);
    chk("t9_counters", {copy_in_opt, copy_out_opt}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t9_no_finished", 64'(fin_cnt - f0), 64'h0);
    chk("t9_cycle", 64'(cyc - t), 64'd26);
    mchk("t9_cur_unwritten", 0, 3, 64'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
